multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle KGP-RISC main decoder.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and handles memory wait states with a ready handshake.
- Evaluates conditional branches from ALU flags and raises a sticky flag on illegal opcodes.
- Sits between the instruction/data memory interface and the datapath register file, ALU and PC.

Parameters:
- OPCODE_W, 6, opcode field width; opcodes at or above 15 are illegal.
- ALUOP_W, 3, width of the alu_op output.
- MEM_WAIT_MAX, 15, wait-cycle limit, used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_opcode  in  OPCODE_W  opcode field of the instruction on the fetch bus.
- mem_ready  in  1  memory completes the current read or write this cycle.
- carry_flag  in  1  ALU carry, sampled in EXEC.
- zero_flag  in  1  ALU zero, sampled in EXEC.
- neg_flag  in  1  ALU negative, sampled in EXEC.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- pc_write  out  1  PC load.
- pc_src  out  2  PC source: 0 = pc+4, 1 = immediate target, 2 = register.
- reg_write  out  1  register file write.
- alu_op  out  ALUOP_W  ALU operation code.
- alusrc  out  2  ALU operand-B select.
- mem_to_reg  out  1  write-back data from memory.
- write_rs  out  1  write-back destination is rs.
- write31  out  1  write-back destination is r31 (link).
- a_zero  out  1  force ALU operand A to 0.
- b_zero  out  1  force ALU operand B to 0.
- illegal_op  out  1  sticky illegal-opcode flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-memory access):
  - state goes to IDLE, latched opcode clears to 0.
  - All outputs 0, including illegal_op.
  - Strobes drop immediately, with no wait for a clock edge.
- IDLE: goes to FETCH on the next edge. There is no other path back into IDLE.
- FETCH:
  - mem_read=1.
  - While mem_ready=0: hold FETCH.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, latch instr_opcode, go to DECODE.
- DECODE: one cycle, no strobes. An opcode of 15 or above sets illegal_op and goes to FETCH. Every other opcode goes to EXEC.
- EXEC drives alu_op, alusrc, a_zero and b_zero per opcode, using the same encoding as the single-cycle decoder:
  - 0 (reg ALU): alusrc 00, alu_op 000. Go to WB.
  - 1 (comp): alusrc 00, alu_op 000, a_zero=1. Go to WB.
  - 2 (addi): alusrc 01, alu_op 101. Go to WB.
  - 3 (compi): alusrc 01, alu_op 110, a_zero=1. Go to WB.
  - 4 (shift immediate): alusrc 10, alu_op 000. Go to WB.
  - 9 (lw) and 10 (sw): alusrc 01, alu_op 001. Go to MEM.
  - 5 (b): pc_write=1, pc_src=1. Go to FETCH.
  - 6 (bl): pc_write=1, pc_src=1, reg_write=1, write31=1. Go to FETCH.
  - 11 (br): pc_write=1, pc_src=2. Go to FETCH.
  - Conditional branches (b_zero=1 for 12-14):
    - 7 (bcy): taken if carry_flag.
    - 8 (bncy): taken if !carry_flag.
    - 12 (bltz): alu_op 010, taken if neg_flag.
    - 13 (bz): alu_op 011, taken if zero_flag.
    - 14 (bnz): alu_op 100, taken if !zero_flag.
  - A taken conditional branch drives pc_write=1, pc_src=1. Taken or not, go to FETCH.
- MEM:
  - lw: mem_read=1; sw: mem_write=1. Hold alu_op and alusrc stable.
  - While mem_ready=0: stay in MEM.
  - When mem_ready=1: lw goes to WB; sw goes to FETCH.
- WB:
  - reg_write=1 for one cycle, then go to FETCH.
  - lw: mem_to_reg=1, write_rs=1.
- Output rules: outputs are Moore decodes of state and latched opcode. They are never X. Any output not listed above is 0.
- Latency with zero-wait memory (cycles from FETCH entry back to FETCH entry): ALU ops 4, lw 5, sw 4, branches 3. Each wait cycle adds 1.
- mem_ready is ignored outside FETCH and MEM.
- illegal_op clears only on reset.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(MEM_WAIT_MAX+1) increments on each FETCH or MEM cycle with mem_ready=0.
  - The counter clears whenever the state changes.
  - When the count reaches MEM_WAIT_MAX with mem_ready still 0: drop the strobes, set a sticky mem_timeout output, go to FETCH.
  - Loads and stores abort with no write-back. A FETCH timeout retries the same PC.
- Not defined: no counter, no mem_timeout port, and the FSM waits indefinitely.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - Opcode localparams OP_ALU..OP_BNZ.
  - State enum IDLE/FETCH/DECODE/EXEC/MEM/WB.
  - ALU op codes and PC_SRC codes.
- Sub-module ctrl_opcode_decode: combinational, latched opcode to alu_op/alusrc/a_zero/b_zero/class (alu, mem, jump, cond). The FSM consumes the class.

Test Plan:
- Reset held, then released → IDLE, then FETCH on the next edge with mem_read=1. Every other output was 0 during reset.
- addi (opcode 2), mem_ready always 1 → ir_write in cycle 1, alu_op=101 and alusrc=01 in cycle 3, reg_write in cycle 4, FETCH in cycle 5.
- lw (opcode 9), mem_ready low for 3 MEM cycles → MEM lasts 4 cycles; WB has mem_to_reg=1 and write_rs=1.
- bz (opcode 13): zero_flag=1 gives pc_write=1, pc_src=1 in EXEC. zero_flag=0 gives no pc_write in EXEC. Both return to FETCH.
- Opcode 6'b111111 → illegal_op=1 after DECODE, no reg_write or mem strobes. A following valid instruction executes normally and illegal_op stays 1.
- rst_n low mid-MEM during sw → mem_write drops asynchronously; state is IDLE after release. With MEM_TIMEOUT_EN, 15 stalled cycles set mem_timeout.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared definitions for the KGP-RISC multi-cycle controller: opcodes, FSM states,
// opcode classes, ALU operation, ALU operand-B and PC source codes.
package kgp_ctrl_pkg;

  // Opcode map inherited from the single-cycle decoder
  localparam int unsigned OP_ALU            = 0;
  localparam int unsigned OP_COMP           = 1;
  localparam int unsigned OP_ADDI           = 2;
  localparam int unsigned OP_COMPI          = 3;
  localparam int unsigned OP_SHIFTI         = 4;
  localparam int unsigned OP_B              = 5;
  localparam int unsigned OP_BL             = 6;
  localparam int unsigned OP_BCY            = 7;
  localparam int unsigned OP_BNCY           = 8;
  localparam int unsigned OP_LW             = 9;
  localparam int unsigned OP_SW             = 10;
  localparam int unsigned OP_BR             = 11;
  localparam int unsigned OP_BLTZ           = 12;
  localparam int unsigned OP_BZ             = 13;
  localparam int unsigned OP_BNZ            = 14;
  // Every opcode at or above this value is illegal
  localparam int unsigned OP_FIRST_ILLEGAL  = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_e;

  // Coarse instruction class; steers the FSM out of EXEC
  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_JUMP,
    CLS_COND
  } op_class_e;

  // ALU operation codes
  localparam logic [2:0] ALU_REG   = 3'b000;
  localparam logic [2:0] ALU_ADDR  = 3'b001;
  localparam logic [2:0] ALU_LTZ   = 3'b010;
  localparam logic [2:0] ALU_ZERO  = 3'b011;
  localparam logic [2:0] ALU_NZ    = 3'b100;
  localparam logic [2:0] ALU_ADDI  = 3'b101;
  localparam logic [2:0] ALU_COMPI = 3'b110;

  // ALU operand-B select codes
  localparam logic [1:0] ALUSRC_REG   = 2'b00;
  localparam logic [1:0] ALUSRC_IMM   = 2'b01;
  localparam logic [1:0] ALUSRC_SHAMT = 2'b10;

  // PC source codes
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_REG   = 2'd2;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational decode of the latched opcode into ALU controls and an instruction class.
module ctrl_opcode_decode
  import kgp_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          alusrc,
  output logic                a_zero,
  output logic                b_zero,
  output op_class_e           op_class
);

  // Opcode table; illegal opcodes decode to all-zero ALU controls
  always_comb begin
    alu_op   = ALUOP_W'(ALU_REG);
    alusrc   = ALUSRC_REG;
    a_zero   = 1'b0;
    b_zero   = 1'b0;
    op_class = CLS_ALU;
    case (opcode)
      OPCODE_W'(OP_ALU): ;
      OPCODE_W'(OP_COMP): a_zero = 1'b1;
      OPCODE_W'(OP_ADDI): begin
        alusrc = ALUSRC_IMM;
        alu_op = ALUOP_W'(ALU_ADDI);
      end
      OPCODE_W'(OP_COMPI): begin
        alusrc = ALUSRC_IMM;
        alu_op = ALUOP_W'(ALU_COMPI);
        a_zero = 1'b1;
      end
      OPCODE_W'(OP_SHIFTI): alusrc = ALUSRC_SHAMT;
      OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): begin
        alusrc   = ALUSRC_IMM;
        alu_op   = ALUOP_W'(ALU_ADDR);
        op_class = CLS_MEM;
      end
      OPCODE_W'(OP_B), OPCODE_W'(OP_BL), OPCODE_W'(OP_BR): op_class = CLS_JUMP;
      OPCODE_W'(OP_BCY), OPCODE_W'(OP_BNCY): op_class = CLS_COND;
      OPCODE_W'(OP_BLTZ): begin
        alu_op   = ALUOP_W'(ALU_LTZ);
        b_zero   = 1'b1;
        op_class = CLS_COND;
      end
      OPCODE_W'(OP_BZ): begin
        alu_op   = ALUOP_W'(ALU_ZERO);
        b_zero   = 1'b1;
        op_class = CLS_COND;
      end
      OPCODE_W'(OP_BNZ): begin
        alu_op   = ALUOP_W'(ALU_NZ);
        b_zero   = 1'b1;
        op_class = CLS_COND;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// KGP-RISC multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// mem_ready handshake, flag-based conditional branches and a sticky illegal-opcode flag.
// Optional macro MEM_TIMEOUT_EN adds a memory wait-cycle limit and a sticky mem_timeout.
// Outputs decode the registered state, so the asynchronous reset clears them at once.
module multicycle_controller
  import kgp_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 6,
  parameter int unsigned ALUOP_W      = 3,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic                mem_ready,
  input  logic                carry_flag,
  input  logic                zero_flag,
  input  logic                neg_flag,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          alusrc,
  output logic                mem_to_reg,
  output logic                write_rs,
  output logic                write31,
  output logic                a_zero,
  output logic                b_zero,
  output logic                illegal_op,
`ifdef MEM_TIMEOUT_EN
  output logic                mem_timeout,
`endif
  output logic                busy
);

  // A zero wait limit would abort every access before memory could answer
  if (MEM_WAIT_MAX == 0) begin : g_wait_max_check
    $error("MEM_WAIT_MAX must be at least 1");
  end

  state_e              state_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal_q;

  logic [ALUOP_W-1:0]  dec_alu_op;
  logic [1:0]          dec_alusrc;
  logic                dec_a_zero;
  logic                dec_b_zero;
  op_class_e           dec_class;

  logic                is_lw;
  logic                is_sw;
  logic                is_bl;
  logic                is_br;
  logic                opcode_illegal;
  logic                cond_taken;

  ctrl_opcode_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .opcode   (opcode_q),
    .alu_op   (dec_alu_op),
    .alusrc   (dec_alusrc),
    .a_zero   (dec_a_zero),
    .b_zero   (dec_b_zero),
    .op_class (dec_class)
  );

  assign is_lw          = (opcode_q == OPCODE_W'(OP_LW));
  assign is_sw          = (opcode_q == OPCODE_W'(OP_SW));
  assign is_bl          = (opcode_q == OPCODE_W'(OP_BL));
  assign is_br          = (opcode_q == OPCODE_W'(OP_BR));
  assign opcode_illegal = (opcode_q >= OPCODE_W'(OP_FIRST_ILLEGAL));

  // Branch condition from the ALU flags presented during EXEC
  always_comb begin
    cond_taken = 1'b0;
    case (opcode_q)
      OPCODE_W'(OP_BCY):  cond_taken = carry_flag;
      OPCODE_W'(OP_BNCY): cond_taken = !carry_flag;
      OPCODE_W'(OP_BLTZ): cond_taken = neg_flag;
      OPCODE_W'(OP_BZ):   cond_taken = zero_flag;
      OPCODE_W'(OP_BNZ):  cond_taken = !zero_flag;
      default:            cond_taken = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              mem_timeout_q;
  logic              stalled;
  logic              wait_hit;

  assign stalled  = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  // This stalled cycle is the MEM_WAIT_MAX-th in a row
  assign wait_hit = stalled && (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

  // Stall counter; zero whenever the FSM is not stalling or leaves the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (stalled && !wait_hit) begin
      wait_q <= wait_q + 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  assign mem_timeout = mem_timeout_q;
`endif

  // Main sequencer: state, latched opcode and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (mem_ready) begin
            opcode_q <= instr_opcode;
            state_q  <= DECODE;
          end
`ifdef MEM_TIMEOUT_EN
          // Fetch timeout: stay in FETCH and re-issue at the same PC
          else if (wait_hit) begin
            mem_timeout_q <= 1'b1;
          end
`endif
        end
        DECODE: begin
          if (opcode_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= FETCH;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          case (dec_class)
            CLS_ALU: state_q <= WB;
            CLS_MEM: state_q <= MEM;
            default: state_q <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            state_q <= is_lw ? WB : FETCH;
          end
`ifdef MEM_TIMEOUT_EN
          // Data timeout: abandon the access, no write-back
          else if (wait_hit) begin
            mem_timeout_q <= 1'b1;
            state_q       <= FETCH;
          end
`endif
        end
        WB:      state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control outputs decoded from state and latched opcode (plus handshake/flags)
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    alu_op     = '0;
    alusrc     = ALUSRC_REG;
    mem_to_reg = 1'b0;
    write_rs   = 1'b0;
    write31    = 1'b0;
    a_zero     = 1'b0;
    b_zero     = 1'b0;
    illegal_op = illegal_q;
    busy       = (state_q != IDLE);
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end
      end
      EXEC: begin
        alu_op = dec_alu_op;
        alusrc = dec_alusrc;
        a_zero = dec_a_zero;
        b_zero = dec_b_zero;
        case (dec_class)
          CLS_JUMP: begin
            pc_write = 1'b1;
            pc_src   = is_br ? PC_REG : PC_IMM;
            if (is_bl) begin
              reg_write = 1'b1;
              write31   = 1'b1;
            end
          end
          CLS_COND: begin
            if (cond_taken) begin
              pc_write = 1'b1;
              pc_src   = PC_IMM;
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        // Address operands held for the whole access
        alu_op    = dec_alu_op;
        alusrc    = dec_alusrc;
      end
      WB: begin
        reg_write = 1'b1;
        if (is_lw) begin
          mem_to_reg = 1'b1;
          write_rs   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
